// File: rtl/calc_cmd_sched_if.sv
// Keypad/core handshake bundle for calc_cmd_sched.
// master: keypad + core side; slave: the scheduler.
interface calc_cmd_sched_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_ready;
    logic [1:0]    calc_status;
    logic [3:0]    cmd_out;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          fault;
    logic [1:0]    fault_code;
    logic          clear;

    modport master (
        output key_valid, key_code, calc_status, clear,
        input  key_ready, cmd_out, busy, fifo_count, overflow, fault, fault_code
    );

    modport slave (
        input  key_valid, key_code, calc_status, clear,
        output key_ready, cmd_out, busy, fifo_count, overflow, fault, fault_code
    );
endinterface

// File: rtl/calc_cmd_sched.sv
// Keypad command FIFO + one-at-a-time issue handshake to the calculator core.
// Optional backspace merging is enabled by defining CMD_SCHED_BKSP_MERGE_EN.
module calc_cmd_sched #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [3:0]  IDLE_CMD    = 4'hD,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic             clock,
    input logic             reset,
    calc_cmd_sched_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitReady, StFault} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];

    logic pop, push, flush, not_full, merge_ok, timed_out;

    assign timed_out = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d      = state_q;
        cmd_d        = IDLE_CMD;
        timer_d      = timer_q;
        fault_code_d = fault_code_q;
        pop          = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && bus.calc_status == 2'b10) begin
                    pop     = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    timer_d = '0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                timer_d = timer_q + TW'(1);
                cmd_d   = cmd_q;
                if (bus.calc_status == 2'b00) begin
                    state_d      = StFault;
                    fault_code_d = 2'b01;
                end else if (bus.calc_status == 2'b01) begin
                    state_d = StWaitReady;
                end else if (timed_out) begin
                    state_d      = StFault;
                    fault_code_d = 2'b10;
                end
            end
            StWaitReady: begin
                timer_d = timer_q + TW'(1);
                if (bus.calc_status == 2'b00) begin
                    state_d      = StFault;
                    fault_code_d = 2'b01;
                end else if (bus.calc_status == 2'b10) begin
                    state_d = StIdle;
                end else if (timed_out) begin
                    state_d      = StFault;
                    fault_code_d = 2'b10;
                end
            end
            StFault: begin
                if (bus.clear) begin
                    state_d      = StIdle;
                    fault_code_d = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase
        // Leaving a wait state for FAULT drops the command and empties the queue.
        if (state_d == StFault && state_q != StFault) begin
            cmd_d = IDLE_CMD;
            flush = 1'b1;
        end
    end

    assign not_full = (count_q < CW'(DEPTH));

`ifdef CMD_SCHED_BKSP_MERGE_EN
    logic [3:0] tail;
    assign tail     = mem_q[wr_ptr_q - PW'(1)];
    // A lone entry being popped this cycle cannot also be merged away.
    assign merge_ok = (bus.key_code == 4'hF) && (count_q != '0) && (tail <= 4'd9) &&
                      !(pop && count_q == CW'(1));
`else
    assign merge_ok = 1'b0;
`endif

    assign bus.key_ready = not_full || pop || merge_ok;
    assign push          = bus.key_valid && !merge_ok && (not_full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.key_code;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            count_d         = count_d + CW'(1);
        end
        if (bus.key_valid && merge_ok) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            count_d  = count_d - CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_d - CW'(1);
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        overflow_d = bus.clear ? 1'b0 : overflow_q;
        if (bus.key_valid && !bus.key_ready) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            cmd_q        <= IDLE_CMD;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            cmd_q        <= cmd_d;
            timer_q      <= timer_d;
            overflow_q   <= overflow_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.cmd_out    = cmd_q;
    assign bus.busy       = (state_q == StWaitAck) || (state_q == StWaitReady);
    assign bus.fault      = (state_q == StFault);
    assign bus.fault_code = fault_code_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched: scoreboard of issued codes plus a simple core model.
module tb_calc_cmd_sched;
    localparam int unsigned DEPTH       = 8;
    localparam logic [3:0]  IDLE_CMD    = 4'hD;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    calc_cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    calc_cmd_sched #(
        .DEPTH      (DEPTH),
        .IDLE_CMD   (IDLE_CMD),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int         total;
    int         bad;
    int         issues;
    int         peak;
    int         busy_cnt;
    bit         auto_core;
    logic [3:0] prev_cmd;
    logic [3:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1ns after the edge, score new issues, step the core model.
    task automatic cyc();
        @(posedge clock);
        #1;
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        if (bus.cmd_out !== IDLE_CMD && prev_cmd === IDLE_CMD) begin
            issues++;
            chk("issue_busy", 32'(bus.busy), 32'(1));
            if (sb.size() == 0) chk("issue_unexpected", 32'(bus.cmd_out), 32'(IDLE_CMD));
            else chk("issue_order", 32'(bus.cmd_out), 32'(sb.pop_front()));
            if (auto_core) begin
                bus.calc_status = 2'b01;
                busy_cnt        = 9;
            end
        end else if (auto_core && busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.calc_status = 2'b10;
        end
        prev_cmd = bus.cmd_out;
    endtask

    task automatic push_key(input logic [3:0] c, input bit exp_ready, input bit enq);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        #1;
        chk("key_ready", 32'(bus.key_ready), 32'(exp_ready));
        if (enq) sb.push_back(c);
        cyc();
        bus.key_valid = 1'b0;
    endtask

    initial begin
        int base;
        int exp_n;
        total = 0; bad = 0; issues = 0; peak = 0; busy_cnt = 0;
        auto_core = 1'b0;
        prev_cmd  = IDLE_CMD;
        bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.calc_status = 2'b10; bus.clear = 1'b0;
        reset = 1'b0;
        #12;
        chk("rst_cmd", 32'(bus.cmd_out), 32'(IDLE_CMD));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_count", 32'(bus.fifo_count), 32'(0));
        chk("rst_overflow", 32'(bus.overflow), 32'(0));
        chk("rst_fault", 32'(bus.fault), 32'(0));
        chk("rst_fault_code", 32'(bus.fault_code), 32'(0));
        reset = 1'b1;
        cyc();

        // In-order issue through the ready/busy core model.
        auto_core = 1'b1; busy_cnt = 0; peak = 0; base = issues;
        push_key(4'h1, 1'b1, 1'b1);
        chk("count_after_push", 32'(bus.fifo_count), 32'(1));
        chk("cmd_before_issue", 32'(bus.cmd_out), 32'(IDLE_CMD));
        push_key(4'h2, 1'b1, 1'b1);
        chk("latency_2clk", 32'(bus.cmd_out), 32'(4'h1));
        push_key(4'hA, 1'b1, 1'b1);
        push_key(4'h3, 1'b1, 1'b1);
        push_key(4'hE, 1'b1, 1'b1);
        repeat (80) cyc();
        chk("t1_issues", 32'(issues - base), 32'(5));
        chk("t1_peak", 32'(peak), 32'(4));
        chk("t1_sb_empty", 32'(sb.size()), 32'(0));
        chk("t1_idle", 32'(bus.busy), 32'(0));

        // Overflow with core stuck busy; clear keeps the queue.
        auto_core = 1'b0; bus.calc_status = 2'b01; base = issues;
        for (int i = 0; i < DEPTH + 2; i++) push_key(4'(i), i < DEPTH, i < DEPTH);
        chk("t2_overflow", 32'(bus.overflow), 32'(1));
        chk("t2_count_full", 32'(bus.fifo_count), 32'(DEPTH));
        chk("t2_not_ready", 32'(bus.key_ready), 32'(0));
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        chk("t2_overflow_cleared", 32'(bus.overflow), 32'(0));
        chk("t2_count_kept", 32'(bus.fifo_count), 32'(DEPTH));
        bus.calc_status = 2'b10; auto_core = 1'b1; busy_cnt = 0;
        repeat (100) cyc();
        chk("t2_issues", 32'(issues - base), 32'(DEPTH));
        chk("t2_sb_empty", 32'(sb.size()), 32'(0));

        // Timeout: core never returns to ready.
        auto_core = 1'b0; bus.calc_status = 2'b10;
        push_key(4'h5, 1'b1, 1'b1);
        cyc();
        bus.calc_status = 2'b01;
        push_key(4'h6, 1'b1, 1'b1);
        push_key(4'h7, 1'b1, 1'b1);
        repeat (TIMEOUT_CYC - 3) cyc();
        chk("t3_no_early_fault", 32'(bus.fault), 32'(0));
        chk("t3_still_busy", 32'(bus.busy), 32'(1));
        cyc();
        chk("t3_fault", 32'(bus.fault), 32'(1));
        chk("t3_fault_code", 32'(bus.fault_code), 32'(2'b10));
        chk("t3_flushed", 32'(bus.fifo_count), 32'(0));
        chk("t3_cmd_idle", 32'(bus.cmd_out), 32'(IDLE_CMD));
        sb.delete();
        bus.calc_status = 2'b10;
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        chk("t3_fault_clr", 32'(bus.fault), 32'(0));
        chk("t3_code_clr", 32'(bus.fault_code), 32'(0));

        // Core error in WAIT_ACK; type-ahead during FAULT issued after clear.
        push_key(4'h3, 1'b1, 1'b1);
        cyc();
        bus.calc_status = 2'b00;
        cyc();
        chk("t4_fault", 32'(bus.fault), 32'(1));
        chk("t4_fault_code", 32'(bus.fault_code), 32'(2'b01));
        chk("t4_cmd_idle", 32'(bus.cmd_out), 32'(IDLE_CMD));
        sb.delete();
        push_key(4'h4, 1'b1, 1'b1);
        push_key(4'h8, 1'b1, 1'b1);
        chk("t4_typeahead", 32'(bus.fifo_count), 32'(2));
        bus.calc_status = 2'b10; auto_core = 1'b1; busy_cnt = 0; base = issues;
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        chk("t4_fault_clr", 32'(bus.fault), 32'(0));
        repeat (30) cyc();
        chk("t4_issues", 32'(issues - base), 32'(2));
        chk("t4_sb_empty", 32'(sb.size()), 32'(0));

        // Asynchronous reset in WAIT_READY with a loaded queue.
        auto_core = 1'b0; bus.calc_status = 2'b10;
        push_key(4'h1, 1'b1, 1'b1);
        cyc();
        bus.calc_status = 2'b01;
        cyc();
        push_key(4'h2, 1'b1, 1'b1);
        push_key(4'h3, 1'b1, 1'b1);
        push_key(4'h5, 1'b1, 1'b1);
        chk("t5_busy", 32'(bus.busy), 32'(1));
        chk("t5_count", 32'(bus.fifo_count), 32'(3));
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_cmd", 32'(bus.cmd_out), 32'(IDLE_CMD));
        chk("t5_rst_count", 32'(bus.fifo_count), 32'(0));
        chk("t5_rst_busy", 32'(bus.busy), 32'(0));
        sb.delete();
        #3 reset = 1'b1;
        prev_cmd = IDLE_CMD;

        // Backspace behind a digit while the core is busy.
        bus.calc_status = 2'b01;
        push_key(4'h5, 1'b1, 1'b1);
        push_key(4'h7, 1'b1, 1'b1);
`ifdef CMD_SCHED_BKSP_MERGE_EN
        push_key(4'hF, 1'b1, 1'b0);
        void'(sb.pop_back());
        chk("t6_merged_count", 32'(bus.fifo_count), 32'(1));
`else
        push_key(4'hF, 1'b1, 1'b1);
        chk("t6_plain_count", 32'(bus.fifo_count), 32'(3));
`endif
        exp_n = sb.size();
        bus.calc_status = 2'b10; auto_core = 1'b1; busy_cnt = 0; base = issues;
        repeat (50) cyc();
        chk("t6_issues", 32'(issues - base), 32'(exp_n));
        chk("t6_sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
